// File: rtl/serial_frame_rx.sv
// Framed command packet receiver: HEADER, CMD, LEN, payload, CHK assembled from UART bytes.
// A checksum-correct frame is held with its payload buffer until the consumer acknowledges it.
module serial_frame_rx #(
    parameter logic [7:0]  HEADER  = 8'h55,
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned TIMEOUT = 50000,
    parameter int unsigned AW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_done,
    output logic          frame_valid,
    output logic [7:0]    frame_cmd,
    output logic [7:0]    frame_len,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    input  logic          frame_ack,
    output logic          err_chk,
    output logic          err_len,
    output logic          err_timeout,
    output logic          drop
);

    localparam int unsigned TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [7:0]  MAX_LEN8 = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        LEN,
        PAYLOAD,
        CHK,
        HOLD
    } state_t;

    state_t        state;
    state_t        nxt;

    logic [7:0]    cmd_r;
    logic [7:0]    len_r;
    logic [7:0]    idx;
    logic [7:0]    sum;
    logic [7:0]    sum_next;
    logic [TW-1:0] tcnt;
    logic [7:0]    mem [2**AW];

    logic          mid_frame;
    logic          tmo_hit;
    logic          chk_bad_n;
    logic          len_bad_n;
    logic          drop_n;

    assign sum_next    = sum + rx_data;
    assign mid_frame   = (state == CMD) || (state == LEN) || (state == PAYLOAD) || (state == CHK);
    // A byte arriving on the expiry cycle wins over the timeout.
    assign tmo_hit     = mid_frame && !rx_done && (tcnt == TW'(TIMEOUT - 1));
    assign frame_valid = (state == HOLD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt       = state;
        chk_bad_n = 1'b0;
        len_bad_n = 1'b0;
        drop_n    = 1'b0;
        if (tmo_hit) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_done && rx_data == HEADER) nxt = CMD;
                end
                CMD: begin
                    if (rx_done) nxt = LEN;
                end
                LEN: begin
                    if (rx_done) begin
                        if (rx_data > MAX_LEN8) begin
                            len_bad_n = 1'b1;
                            nxt       = IDLE;
                        end else if (rx_data == 8'd0) begin
                            nxt = CHK;
                        end else begin
                            nxt = PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (rx_done && idx == len_r - 8'd1) nxt = CHK;
                end
                CHK: begin
                    if (rx_done) begin
                        if (sum_next == 8'd0) begin
                            nxt = HOLD;
                        end else begin
                            chk_bad_n = 1'b1;
                            nxt       = IDLE;
                        end
                    end
                end
                HOLD: begin
                    drop_n = rx_done;
                    if (frame_ack) nxt = IDLE;
                end
                default: nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_r       <= '0;
            len_r       <= '0;
            idx         <= '0;
            sum         <= '0;
            tcnt        <= '0;
            frame_cmd   <= '0;
            frame_len   <= '0;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            drop        <= 1'b0;
        end else begin
            err_chk     <= chk_bad_n;
            err_len     <= len_bad_n;
            err_timeout <= tmo_hit;
            drop        <= drop_n;

            if (!mid_frame || rx_done || tmo_hit) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end

            if (rx_done) begin
                case (state)
                    CMD: begin
                        cmd_r <= rx_data;
                        sum   <= rx_data;
                    end
                    LEN: begin
                        sum <= sum_next;
                        idx <= '0;
                        if (rx_data <= MAX_LEN8) len_r <= rx_data;
                    end
                    PAYLOAD: begin
                        sum <= sum_next;
                        idx <= idx + 8'd1;
                    end
                    CHK: begin
                        if (sum_next == 8'd0) begin
                            frame_cmd <= cmd_r;
                            frame_len <= len_r;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == PAYLOAD && rx_done) mem[idx[AW-1:0]] <= rx_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: expected frames queued as sent, popped as frame_valid rises.
module tb_serial_frame_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_done = 1'b0;
    logic       frame_valid;
    logic [7:0] frame_cmd;
    logic [7:0] frame_len;
    logic [3:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       frame_ack = 1'b0;
    logic       err_chk;
    logic       err_len;
    logic       err_timeout;
    logic       drop;

    int total = 0;
    int bad = 0;
    int n_chk = 0;
    int n_len = 0;
    int n_tmo = 0;
    int n_drop = 0;
    logic fv_q = 1'b0;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] len;
    } exp_t;
    exp_t exp_q[$];

    serial_frame_rx #(
        .HEADER (8'h55),
        .MAX_LEN(16),
        .TIMEOUT(100),
        .AW     (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .frame_valid(frame_valid),
        .frame_cmd  (frame_cmd),
        .frame_len  (frame_len),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .frame_ack  (frame_ack),
        .err_chk    (err_chk),
        .err_len    (err_len),
        .err_timeout(err_timeout),
        .drop       (drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse counters and scoreboard pop, sampled mid-cycle.
    always @(negedge clk) begin
        if (err_chk) n_chk++;
        if (err_len) n_len++;
        if (err_timeout) n_tmo++;
        if (drop) n_drop++;
        if (frame_valid && !fv_q) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_frame observed cmd=%0h len=%0h expected none", frame_cmd, frame_len);
            end
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_cmd", frame_cmd, e.cmd);
                check("sb_len", frame_len, e.len);
            end
        end
        fv_q = frame_valid;
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
    endtask

    task automatic read(input logic [3:0] a, input logic [7:0] exp, input string tag);
        @(negedge clk);
        rd_addr = a;
        @(posedge clk);
        #1;
        check(tag, rd_data, exp);
    endtask

    task automatic ack();
        @(negedge clk);
        frame_ack = 1'b1;
        @(posedge clk);
        #1;
        frame_ack = 1'b0;
        check("ack_valid_low", frame_valid, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, frame_valid, 1'b0);
        check({tag, "_cmd"}, frame_cmd, 8'h00);
        check({tag, "_len"}, frame_len, 8'h00);
        check({tag, "_rd"}, rd_data, 8'h00);
        check({tag, "_errs"}, {err_chk, err_len, err_timeout, drop}, 4'b0000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        // 1: good frame, payload readback, ack
        send(8'h55); send(8'h01); send(8'h02); send(8'h10); send(8'h20);
        check("t1_pre_valid", frame_valid, 1'b0);
        exp_q.push_back('{8'h01, 8'h02});
        send(8'hCD);
        check("t1_valid", frame_valid, 1'b1);
        check("t1_cmd", frame_cmd, 8'h01);
        check("t1_len", frame_len, 8'h02);
        read(4'd0, 8'h10, "t1_rd0");
        read(4'd1, 8'h20, "t1_rd1");
        ack();

        // 2: bad checksum, then zero-length frame
        send(8'h55); send(8'h01); send(8'h02); send(8'h10); send(8'h20);
        send(8'hCC);
        check("t2_err_chk", err_chk, 1'b1);
        check("t2_no_valid", frame_valid, 1'b0);
        @(posedge clk); #1;
        check("t2_chk_single", err_chk, 1'b0);
        check("t2_cmd_kept", frame_cmd, 8'h01);
        send(8'h55); send(8'h07); send(8'h00);
        exp_q.push_back('{8'h07, 8'h00});
        send(8'hF9);
        check("t2_valid", frame_valid, 1'b1);
        check("t2_len", frame_len, 8'h00);
        ack();

        // 3: length over limit, trailing bytes ignored, then good frame
        send(8'h55); send(8'h03); send(8'h11);
        check("t3_err_len", err_len, 1'b1);
        send(8'h10); send(8'h20);
        check("t3_no_valid", frame_valid, 1'b0);
        send(8'h55); send(8'h01); send(8'h01); send(8'hAA);
        exp_q.push_back('{8'h01, 8'h01});
        send(8'h54);
        check("t3_valid", frame_valid, 1'b1);
        read(4'd0, 8'hAA, "t3_rd0");
        ack();

        // 4: inter-byte timeout
        send(8'h55); send(8'h01);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (err_timeout) begin
                n = i;
                break;
            end
        end
        check("t4_tmo_cycles", n, 100);
        @(posedge clk); #1;
        check("t4_tmo_single", err_timeout, 1'b0);
        send(8'h55); send(8'h02); send(8'h00);
        exp_q.push_back('{8'h02, 8'h00});
        send(8'hFE);
        check("t4_valid", frame_valid, 1'b1);
        ack();

        // 5: drop while held, then simultaneous rx_done + ack
        send(8'h55); send(8'h09); send(8'h01); send(8'h33);
        exp_q.push_back('{8'h09, 8'h01});
        send(8'hC3);
        send(8'h55);
        check("t5_drop", drop, 1'b1);
        check("t5_hold_valid", frame_valid, 1'b1);
        check("t5_hold_cmd", frame_cmd, 8'h09);
        check("t5_hold_len", frame_len, 8'h01);
        ack();
        send(8'h55); send(8'h04); send(8'h00);
        exp_q.push_back('{8'h04, 8'h00});
        send(8'hFC);
        check("t5_valid2", frame_valid, 1'b1);
        @(negedge clk);
        rx_data = 8'h55;
        rx_done = 1'b1;
        frame_ack = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
        frame_ack = 1'b0;
        check("t5_sim_drop", drop, 1'b1);
        check("t5_sim_idle", frame_valid, 1'b0);
        send(8'h07); send(8'h00); send(8'hF9);
        check("t5_no_frame", frame_valid, 1'b0);
        send(8'h55); send(8'h0A); send(8'h00);
        exp_q.push_back('{8'h0A, 8'h00});
        send(8'hF6);
        check("t5_valid3", frame_valid, 1'b1);
        ack();

        // 6: leading garbage, then reset mid-payload
        send(8'hAA); send(8'h13);
        send(8'h55); send(8'h02); send(8'h00);
        exp_q.push_back('{8'h02, 8'h00});
        send(8'hFE);
        check("t6_valid", frame_valid, 1'b1);
        check("t6_cmd", frame_cmd, 8'h02);
        ack();
        send(8'h55); send(8'h05); send(8'h03); send(8'h11); send(8'h22);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("t6_rst");
        @(negedge clk);
        rst = 1'b1;
        send(8'h33); send(8'hC0);
        check("t6_no_frame", frame_valid, 1'b0);
        send(8'h55); send(8'h06); send(8'h02); send(8'h01); send(8'h02);
        exp_q.push_back('{8'h06, 8'h02});
        send(8'hF5);
        check("t6_valid2", frame_valid, 1'b1);
        read(4'd0, 8'h01, "t6_rd0");
        read(4'd1, 8'h02, "t6_rd1");
        ack();

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", exp_q.size(), 0);
        check("cnt_chk", n_chk, 1);
        check("cnt_len", n_len, 1);
        check("cnt_tmo", n_tmo, 1);
        check("cnt_drop", n_drop, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
